det_arbiter: RTL and testbench
==============================

# det_arbiter

Shares one serial pattern detector between two requesters. Each requester submits a parallel word over a valid/ready handshake. The controller arbitrates, serialises the granted word MSB-first into the detector, and counts detector hits. It then returns the hit count and requester id over a response handshake. It sits between the word-level producers and the bit-serial detection datapath.

## Interface
- WORD_W, default 8: bits per submitted word; must be ≥ 4.
- CNT_W, default 4: width of the hit count; the count saturates at 2^CNT_W−1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WORD_W  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WORD_W  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- rsp_valid  out  1  result available.
- rsp_id  out  1  requester that owns the result.
- rsp_count  out  CNT_W  hits in that word.
- rsp_ready  in  1  consumer takes the result.

## Operation
- Detector states are S0, S1, S2, S3. All transitions are registered. The detector output y is a Mealy output.
  - S0: x=1 goes to S1; x=0 stays in S0.
  - S1: x=1 goes to S2; x=0 stays in S1.
  - S2: x=1 stays in S2; x=0 goes to S3.
  - S3: x=1 goes to S0; x=0 goes to S1.
  - y=1 only when the state is S3 and x=1.
  - A synchronous clr input forces the detector to S0. It has priority over x.
- Controller states are IDLE, SHIFT and RESP.
- IDLE:
  - The grant is computed combinationally from the valids and the priority pointer.
  - reqN_ready = (IDLE) && granted N && reqN_valid.
  - On a transfer: the word is latched into the shift register, rsp_id is set to N, the count is cleared, the bit index is set to WORD_W−1, and the state moves to SHIFT.
  - The detector is held in clr during IDLE, and the pointer flips to the other requester.
- SHIFT:
  - Each cycle, one bit (MSB first) drives detector x. clr is low.
  - When y=1, the count increments, saturating at 2^CNT_W−1.
  - After the bit at index 0, the state moves to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_count are stable.
  - When rsp_valid && rsp_ready, the state returns to IDLE.
  - Both ready outputs are 0 in SHIFT and RESP.
- The detector state never carries over between words.
- Reset, including mid-SHIFT or mid-RESP:
  - State goes to IDLE, the detector to S0, and the pointer to favour req0.
  - rsp_valid=0, rsp_id=0, rsp_count=0, shift register 0. The in-flight word is dropped.
  - Combinationally, req0_ready=0 and req1_ready=0 while rst is low.
- Requester data is sampled only on the transfer cycle. Changes at any other time are ignored.

## Timing
- Cycle 0: transfer (valid&&ready).
- Cycles 1 to WORD_W: one bit per cycle.
- Cycle WORD_W+1: rsp_valid first high, and it is registered.
- If rsp_ready is high in that cycle, the state is IDLE at cycle WORD_W+2. The next transfer can occur there, giving a throughput of one word per WORD_W+2 cycles.
- A hit on the last bit is included in rsp_count.
- Back-pressure: rsp_valid, rsp_id and rsp_count hold indefinitely while rsp_ready=0. No new word is accepted during that time.
- There is no combinational path from rsp_ready to any output.

## Configuration
- DET_RR_ARB_EN defined:
  - The grant is round-robin.
  - When both valids are high, the requester indicated by the pointer wins.
  - The pointer moves to the non-winner after each transfer.
  - A single valid always wins regardless of the pointer.
- DET_RR_ARB_EN undefined:
  - The grant is fixed priority, with req0 always winning a tie.
  - There is no pointer register.

## Structure
- A shared package det_pkg holds:
  - the controller state typedef (IDLE/SHIFT/RESP);
  - the detector state typedef (S0–S3);
  - the default WORD_W and CNT_W constants.
- One sub-module, det_pattern_fsm (clk, rst, clr, x, y), implements the detector exactly as described in Operation.
- The arbiter, shift register, bit index, counter and handshake logic live in det_arbiter.

## Test plan
- Single word, no hits: req0 word 8'h00 → req0_ready at cycle 0, rsp_valid at cycle 9, rsp_id=0, rsp_count=0.
- Single hits: req1 word 8'b1101_0000 → rsp_id=1, rsp_count=1. req1 word 8'b1011_0101 → rsp_count=1 (hit on bit 2).
- Two hits: word 8'b1101_1101 → rsp_count=2, with the hit on bit 0 counted.
- Saturation: with CNT_W=1, word 8'b1101_1101 → rsp_count=1.
- Arbitration: both valids high continuously after reset, rsp_ready=1.
  - With DET_RR_ARB_EN: rsp_id sequence 0,1,0,1.
  - Without DET_RR_ARB_EN: rsp_id sequence 0,0,0,0.
- Back-pressure and reset:
  - Hold rsp_ready=0 for 5 cycles → outputs stable, both readys 0.
  - Assert rst in the middle of SHIFT → rsp_valid=0, readys 0 immediately.
  - Then submit 8'b1101_0000 → rsp_count=1 (no residue from the dropped word).

Source files
------------

// File: rtl/det_pkg.sv
// Shared types and default sizing for the det_arbiter block.
package det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/det_pattern_fsm.sv
// Four-state serial pattern detector with a Mealy hit output and a
// synchronous clear that overrides the serial input.
module det_pattern_fsm
    import det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic x,
    output logic y
);

    det_state_t state_r;

    // Detector state register; clr returns to S0 regardless of x
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S0;
        end else if (clr) begin
            state_r <= S0;
        end else begin
            case (state_r)
                S0:      state_r <= x ? S1 : S0;
                S1:      state_r <= x ? S2 : S1;
                S2:      state_r <= x ? S2 : S3;
                S3:      state_r <= x ? S0 : S1;
                default: state_r <= S0;
            endcase
        end
    end

    assign y = (state_r == S3) && x;

endmodule

// File: rtl/det_arbiter.sv
// Two-requester front end for the shared serial detector: arbitrate, shift the
// granted word MSB-first, count hits, return the count with the requester id.
// Define DET_RR_ARB_EN for round-robin grant; default is fixed priority to req0.
module det_arbiter
    import det_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [CNT_W-1:0]  rsp_count,
    input  logic              rsp_ready
);

    localparam int IDX_W = $clog2(WORD_W);

    ctrl_state_t       state_r;
    logic [WORD_W-1:0] shreg_r;
    logic [IDX_W-1:0]  idx_r;
    logic              grant_s;
    logic              xfer_s;
    logic              hit_s;
    logic              clr_s;
    logic              x_s;

`ifdef DET_RR_ARB_EN
    logic              ptr_r;

    // Tie-break pointer: after each transfer it favours the requester that lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= 1'b0;
        end else if (xfer_s) begin
            ptr_r <= ~grant_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Round-robin grant: a lone valid always wins, ties go to the pointer
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ptr_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end
`else
    // Fixed-priority grant: req0 wins whenever it is valid
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid) begin
            grant_s = 1'b0;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end
`endif

    // rst appears here so both readys drop the instant reset is asserted
    assign req0_ready = rst && (state_r == IDLE) && !grant_s && req0_valid;
    assign req1_ready = rst && (state_r == IDLE) &&  grant_s && req1_valid;
    assign xfer_s     = req0_ready || req1_ready;

    // Detector only runs while shifting, so no state leaks between words
    assign clr_s = (state_r != SHIFT);
    assign x_s   = shreg_r[idx_r];

    det_pattern_fsm u_det (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .x   (x_s),
        .y   (hit_s)
    );

    // Controller: accept a word, shift it out, then hold the result until taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            shreg_r   <= {WORD_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_count <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        shreg_r   <= grant_s ? req1_data : req0_data;
                        rsp_id    <= grant_s;
                        rsp_count <= {CNT_W{1'b0}};
                        idx_r     <= IDX_W'(WORD_W - 1);
                        state_r   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (hit_s && (rsp_count != {CNT_W{1'b1}})) begin
                        rsp_count <= rsp_count + CNT_W'(1);
                    end
                    if (idx_r == {IDX_W{1'b0}}) begin
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
                    end else begin
                        idx_r <= idx_r - IDX_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_det_arbiter.sv
// Randomised scoreboard bench for det_arbiter; a second instance with a 1-bit
// counter shares the stimulus so saturation is checked on every response.
module tb_det_arbiter;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;
    localparam int LAT    = WORD_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
    logic [WORD_W-1:0] req0_data = '0, req1_data = '0;
    logic              req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [CNT_W-1:0]  rsp_count;
    logic              s_r0, s_r1, s_valid, s_id;
    logic [0:0]        s_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_rsp  = 0;

    typedef struct { bit id; int hits; int cyc; } exp_t;
    exp_t q[$];
    bit   ids_seen[$];
    bit   ptr_m = 1'b0;

    det_arbiter #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count),
        .rsp_ready(rsp_ready)
    );

    det_arbiter #(.WORD_W(WORD_W), .CNT_W(1)) u_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_r1),
        .rsp_valid(s_valid), .rsp_id(s_id), .rsp_count(s_count),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual %0d required %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference: walk the detector rules bit by bit, MSB first, from S0
    function automatic int ref_hits(input logic [WORD_W-1:0] w);
        int nxt [4][2];
        int st = 0;
        int h  = 0;
        nxt = '{'{0, 1}, '{1, 2}, '{3, 2}, '{1, 0}};
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (st == 3 && w[i]) h++;
            st = nxt[st][w[i]];
        end
        return h;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Monitor: predicts readys and responses, pushes on transfer, pops on handshake
    always @(negedge clk) begin
        bit win, e0, e1, ev;
        if (!rst) begin
            chk("rst_readys", {req1_ready, req0_ready}, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_count", rsp_count, 0);
            q.delete();
            ptr_m = 1'b0;
        end else begin
            e0 = 1'b0; e1 = 1'b0; win = 1'b0;
            if (q.size() == 0 && (req0_valid || req1_valid)) begin
`ifdef DET_RR_ARB_EN
                win = (req0_valid && req1_valid) ? ptr_m : req1_valid;
                ptr_m = ~win;
`else
                win = !req0_valid;
`endif
                e0 = !win; e1 = win;
                q.push_back('{win, ref_hits(win ? req1_data : req0_data), cyc});
            end
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            ev = (q.size() > 0) && (cyc >= q[0].cyc + LAT);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_count", rsp_count, sat(q[0].hits, 15));
                chk("sat_count", s_count, sat(q[0].hits, 1));
                if (rsp_ready) begin
                    ids_seen.push_back(rsp_id);
                    void'(q.pop_front());
                    n_rsp++;
                end
            end
        end
    end

    task automatic send(input bit who, input logic [WORD_W-1:0] w);
        int k = 0;
        @(posedge clk); #1;
        if (who) begin req1_valid = 1'b1; req1_data = w; end
        else     begin req0_valid = 1'b1; req0_data = w; end
        do begin
            @(negedge clk);
            k++;
        end while (!(who ? req1_ready : req0_ready) && k < 200);
        if (k >= 200) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = WORD_W'($urandom); req1_data = WORD_W'($urandom);
    endtask

    task automatic wait_rsp(input int target);
        int k = 0;
        while (n_rsp < target && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        if (n_rsp < target) chk("rsp_timeout", n_rsp, target);
    endtask

    task automatic send_wait(input bit who, input logic [WORD_W-1:0] w);
        int t = n_rsp + 1;
        send(who, w);
        wait_rsp(t);
    endtask

    initial begin
        int t;
        int k;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Both requesters valid continuously from reset
        t = n_rsp + 4;
        ids_seen.delete();
        req0_valid = 1'b1; req1_valid = 1'b1;
        k = 0;
        while (n_rsp < t && k < 200) begin
            @(posedge clk); #1;
            req0_data = WORD_W'($urandom); req1_data = WORD_W'($urandom);
            k++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("arb_count", ids_seen.size(), 4);
        for (int i = 0; i < 4 && i < ids_seen.size(); i++) begin
`ifdef DET_RR_ARB_EN
            chk("arb_id_seq", ids_seen[i], i % 2);
`else
            chk("arb_id_seq", ids_seen[i], 0);
`endif
        end

        send_wait(1'b0, 8'h00);
        send_wait(1'b1, 8'b1101_0000);
        send_wait(1'b1, 8'b1011_0101);
        send_wait(1'b0, 8'b1101_1101);

        // Back-pressure with a competing requester held valid
        rsp_ready = 1'b0;
        t = n_rsp + 1;
        send(1'b0, 8'b1101_1101);
        k = 0;
        while (!rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
        req1_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp(t);

        // Reset in the middle of SHIFT, then a clean word
        send(1'b1, 8'b1111_1101);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; req0_valid = 1'b0;
        send_wait(1'b1, 8'b1101_0000);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_data  = WORD_W'($urandom);
            req1_data  = WORD_W'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
        chk("drain", q.size(), 0);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
